mem_burst_initiator: RTL and testbench
======================================

# mem_burst_initiator

Memory-side initiator for the GPN kernel's vertex/edge memory ports. It accepts read/write burst commands from kernel logic, issues single-cycle StartRead/StartWrite requests with held address and burst fields, streams write beats out of a local buffer and collects returning read beats into an output FIFO. It sits between the kernel request arbiters and the memory port, one instance per port: vertex at DATA_WIDTH 256, edge at 512.

## Interface
- ADDR_WIDTH, 33, byte address width.
- DATA_WIDTH, 256, beat width.
- FIFO_DEPTH, 32, entries in each of the read and write buffers; power of two; maximum beats per burst.
- TIMEOUT_CYCLES, 1024, stall limit; used only with the timeout feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  burst start byte address.
- cmd_len  in  8  beats minus 1.
- wdata_valid / wdata_ready  in / out  1 / 1  write-beat handshake.
- wdata  in  DATA_WIDTH  write beat.
- rdata_valid / rdata_ready  out / in  1 / 1  read-beat handshake.
- rdata  out  DATA_WIDTH  read beat.
- rdata_last  out  1  final beat of a burst.
- StartWrite  out  1  one-cycle write request.
- WriteAddress  out  ADDR_WIDTH  write start address.
- WriteBurst  out  8  write beats minus 1.
- WriteStrobe  out  DATA_WIDTH/8  byte enables.
- WriteData  out  DATA_WIDTH  write beat.
- WriteReady  out  1  WriteData valid this cycle.
- WriteResp  in  1  memory acknowledge; informational only.
- EndWrite  in  2  bit 0 pulses at write completion.
- StartRead  out  1  one-cycle read request.
- ReadAddress  out  ADDR_WIDTH  read start address.
- ReadBurst  out  8  read beats minus 1.
- ReadData  in  DATA_WIDTH  read beat.
- ReadReady  in  1  ReadData valid this cycle.
- EndRead  in  1  marks the final read beat.
- busy  out  1  state != IDLE.
- cmd_err  out  1  sticky; set when cmd_len+1 > FIFO_DEPTH.
- protocol_err  out  1  sticky; set when ReadReady arrives outside RD_WAIT or EndWrite[0] arrives outside WR_WAIT.
- timeout_err  out  1  sticky stall flag.

Reset values: every output is 0 except cmd_ready = 1 and WriteStrobe = all ones. Both FIFOs are emptied.

## Operation
States:
- IDLE: cmd_ready = 1.
  - On a command handshake with illegal length: set cmd_err and remain in IDLE. No memory request is issued.
  - Read: latch addr and len; go to RD_ISSUE.
  - Write: latch addr and len; go to WR_FILL.
- RD_ISSUE: wait until read-FIFO free entries >= len+1. Then pulse StartRead for one cycle and go to RD_WAIT.
- RD_WAIT: each cycle with ReadReady = 1, push {ReadData, EndRead} into the read FIFO. A beat that also has EndRead = 1 completes the burst and the next state is IDLE. The beat count is not checked.
- WR_FILL: wdata_ready = 1. Accept exactly len+1 beats into the write FIFO, then go to WR_ISSUE.
- WR_ISSUE: pulse StartWrite for one cycle, then go to WR_SEND.
- WR_SEND: pop one beat per cycle with WriteReady = 1 for exactly len+1 consecutive cycles, then go to WR_WAIT.
- WR_WAIT: when EndWrite[0] = 1, go to IDLE.

Rules:
- Address and burst outputs hold their latched values from the Start cycle until the state leaves RD_WAIT / WR_WAIT. They are 0 when idle.
- The read FIFO pops on rdata_valid && rdata_ready, with rdata/rdata_last at the FIFO head. Pops proceed in every state, including RD_WAIT.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap. Full and empty are decoded from the MSB.
- Simultaneous push and pop on the read FIFO is allowed; a FIFO of depth N holds up to N entries.
- An asynchronous reset mid-burst aborts immediately: FIFOs flushed, Start* and WriteReady deasserted.

## Timing
- Command to StartRead: 1 cycle minimum.
- StartRead at cycle T; the first ReadReady occurs at T+1 or later.
- A read beat pushed at cycle t is visible on rdata_valid at t+1.
- Write: StartWrite at cycle T, WriteReady cycles T+1 .. T+1+len, EndWrite[0] accepted at T+2+len or later.
- The next Start* is issued no earlier than the cycle after EndRead or EndWrite[0] is seen.

## Configuration
- MEM_INIT_TIMEOUT_EN defined: a counter runs in RD_WAIT and WR_WAIT and clears on each ReadReady or EndWrite[0]. When it reaches TIMEOUT_CYCLES, the block sets timeout_err and forces IDLE. Beats already pushed are kept.
- MEM_INIT_TIMEOUT_EN undefined: no counter is built; timeout_err is tied to 0.

## Structure
- mem_init_pkg holds:
  - the state enum;
  - the cmd struct {write, addr, len};
  - LEN_W = 8.
- The sub-module mem_init_fifo is a parameterised synchronous FIFO (width, depth) with a free-count output. It is instantiated twice: write data, and read {data, last}.

## Test plan
- Read burst: addr 0x100, len 3, rdata_ready = 1 → one StartRead pulse with ReadBurst = 3; 4 rdata beats in order; rdata_last on beat 4; busy drops after EndRead.
- Write burst: len 7, 8 wdata beats supplied → StartWrite, then 8 consecutive WriteReady cycles carrying the beats in order; WriteStrobe all ones; IDLE after EndWrite[0].
- Back-pressure: rdata_ready = 0 with FIFO_DEPTH = 32, two reads of len 15 then a third → the third StartRead is withheld until ≥16 pops occur.
- Illegal command: cmd_len = 40 with FIFO_DEPTH = 32 → cmd_err = 1, no Start* pulse, cmd_ready remains 1.
- Reset asserted in WR_SEND after 3 beats → WriteReady drops asynchronously and all outputs return to reset values; the next read command completes normally.
- With MEM_INIT_TIMEOUT_EN and TIMEOUT_CYCLES = 16, a read with no ReadReady → timeout_err = 1 at 16 cycles, block returns to IDLE.

Source files
------------

// File: rtl/mem_init_pkg.sv
// mem_init_pkg: shared state encoding, command record and widths for mem_burst_initiator
package mem_init_pkg;
  localparam int LEN_W = 8;
  localparam int ADDR_MAX_W = 64;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_FILL, WR_ISSUE, WR_SEND, WR_WAIT} state_e;
  typedef struct packed {
    logic                  write;
    logic [ADDR_MAX_W-1:0] addr;
    logic [LEN_W-1:0]      len;
  } cmd_t;
endpackage

// File: rtl/mem_init_fifo.sv
// mem_init_fifo: synchronous FIFO with wrap-bit pointers and a free-entry count
module mem_init_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [AW:0]  free_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic full, do_push, do_pop;
  assign empty_o = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign dout_o = mem_q[rp_q[AW-1:0]];
  assign free_o = (AW+1)'(DEPTH) - (wp_q - rp_q);
  // storage needs no reset; only the pointers define contents
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  // pointers wrap through the extra MSB so full and empty differ
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
    end
endmodule

// File: rtl/mem_burst_initiator.sv
// mem_burst_initiator: burst command to memory-port initiator; stall timeout built only when MEM_INIT_TIMEOUT_EN is defined
module mem_burst_initiator
  import mem_init_pkg::*;
#(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_last,
  output logic                    StartWrite,
  output logic [ADDR_WIDTH-1:0]   WriteAddress,
  output logic [LEN_W-1:0]        WriteBurst,
  output logic [DATA_WIDTH/8-1:0] WriteStrobe,
  output logic [DATA_WIDTH-1:0]   WriteData,
  output logic                    WriteReady,
  input  logic                    WriteResp,
  input  logic [1:0]              EndWrite,
  output logic                    StartRead,
  output logic [ADDR_WIDTH-1:0]   ReadAddress,
  output logic [LEN_W-1:0]        ReadBurst,
  input  logic [DATA_WIDTH-1:0]   ReadData,
  input  logic                    ReadReady,
  input  logic                    EndRead,
  output logic                    busy,
  output logic                    cmd_err,
  output logic                    protocol_err,
  output logic                    timeout_err
);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q;
  cmd_t cmd_q;
  logic [LEN_W-1:0] beat_q;
  logic start_rd_q, start_wr_q, wr_ready_q, cmd_err_q, prot_err_q;
  logic to_hit, len_bad, rd_room, rd_push, wr_push, proto, rd_hold, wr_hold;
  logic [PW-1:0] rd_free, wr_free;
  logic rd_empty, wr_empty;
  logic [DATA_WIDTH:0] rd_head;
  logic [DATA_WIDTH-1:0] wr_head;
  logic unused_ok;
  assign len_bad = int'(cmd_len) >= FIFO_DEPTH;
  assign rd_room = int'(rd_free) > int'(cmd_q.len);
  assign rd_push = state_q == RD_WAIT && ReadReady;
  assign wr_push = state_q == WR_FILL && wdata_valid;
  assign proto = (ReadReady && state_q != RD_WAIT) || (EndWrite[0] && state_q != WR_WAIT);
  assign rd_hold = state_q == RD_WAIT;
  assign wr_hold = state_q == WR_SEND || state_q == WR_WAIT;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign wdata_ready = state_q == WR_FILL;
  assign StartRead = start_rd_q;
  assign StartWrite = start_wr_q;
  assign WriteReady = wr_ready_q;
  assign WriteStrobe = '1;
  assign WriteData = wr_ready_q ? wr_head : '0;
  assign ReadAddress = rd_hold ? cmd_q.addr[ADDR_WIDTH-1:0] : '0;
  assign ReadBurst = rd_hold ? cmd_q.len : '0;
  assign WriteAddress = wr_hold ? cmd_q.addr[ADDR_WIDTH-1:0] : '0;
  assign WriteBurst = wr_hold ? cmd_q.len : '0;
  assign rdata_valid = !rd_empty;
  assign {rdata, rdata_last} = rdata_valid ? rd_head : '0;
  assign cmd_err = cmd_err_q;
  assign protocol_err = prot_err_q;
  assign unused_ok = ^{WriteResp, EndWrite[1], cmd_q.write, cmd_q.addr >> ADDR_WIDTH, wr_free, wr_empty, 32'(TIMEOUT_CYCLES)};

  mem_init_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk(clk), .reset(reset), .push_i(wr_push), .din_i(wdata), .pop_i(wr_ready_q),
    .dout_o(wr_head), .free_o(wr_free), .empty_o(wr_empty)
  );

  mem_init_fifo #(.W(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk(clk), .reset(reset), .push_i(rd_push), .din_i({ReadData, EndRead}),
    .pop_i(rdata_valid && rdata_ready), .dout_o(rd_head), .free_o(rd_free), .empty_o(rd_empty)
  );

`ifdef MEM_INIT_TIMEOUT_EN
  logic [31:0] to_q;
  logic to_err_q, waiting, progress;
  assign waiting = state_q == RD_WAIT || state_q == WR_WAIT;
  assign progress = ReadReady || EndWrite[0];
  assign to_hit = waiting && !progress && to_q == 32'(TIMEOUT_CYCLES - 1);
  assign timeout_err = to_err_q;
  // stall counter runs while waiting on memory and clears on any progress
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      to_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_q <= (waiting && !progress && !to_hit) ? to_q + 32'd1 : '0;
      if (to_hit) to_err_q <= 1'b1;
    end
`else
  assign to_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // burst sequencer: command latch, request pulses, beat counting and sticky errors
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      beat_q <= '0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      wr_ready_q <= 1'b0;
      cmd_err_q <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      if (proto) prot_err_q <= 1'b1;
      case (state_q)
        IDLE:
          if (cmd_valid) begin
            if (len_bad) cmd_err_q <= 1'b1;
            else begin
              cmd_q <= '{cmd_write, ADDR_MAX_W'(cmd_addr), cmd_len};
              beat_q <= '0;
              state_q <= cmd_write ? WR_FILL : RD_ISSUE;
            end
          end
        RD_ISSUE:
          if (rd_room) begin
            start_rd_q <= 1'b1;
            state_q <= RD_WAIT;
          end
        RD_WAIT:
          if (to_hit || (ReadReady && EndRead)) state_q <= IDLE;
        WR_FILL:
          if (wdata_valid) begin
            beat_q <= (beat_q == cmd_q.len) ? '0 : beat_q + 8'd1;
            if (beat_q == cmd_q.len) state_q <= WR_ISSUE;
          end
        WR_ISSUE: begin
          start_wr_q <= 1'b1;
          state_q <= WR_SEND;
        end
        WR_SEND:
          if (start_wr_q) wr_ready_q <= 1'b1;
          else if (beat_q == cmd_q.len) begin
            wr_ready_q <= 1'b0;
            beat_q <= '0;
            state_q <= WR_WAIT;
          end else beat_q <= beat_q + 8'd1;
        WR_WAIT:
          if (to_hit || EndWrite[0]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_burst_initiator.sv
// tb_mem_burst_initiator: directed scoreboard bench for mem_burst_initiator (timeout step active with MEM_INIT_TIMEOUT_EN)
module tb_mem_burst_initiator;
  localparam int AW = 33, DW = 64, DEPTH = 32;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic wdata_valid = 0, wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic rdata_valid, rdata_ready = 0, rdata_last;
  logic [DW-1:0] rdata;
  logic StartWrite, WriteReady, WriteResp = 0, StartRead;
  logic [AW-1:0] WriteAddress, ReadAddress;
  logic [7:0] WriteBurst, ReadBurst;
  logic [DW/8-1:0] WriteStrobe;
  logic [DW-1:0] WriteData, ReadData = '0;
  logic [1:0] EndWrite = '0;
  logic ReadReady = 0, EndRead = 0;
  logic busy, cmd_err, protocol_err, timeout_err;
  int total = 0, passed = 0, nfail = 0, n_srd = 0, n_swr = 0;
  logic [DW:0] rq[$];
  logic [DW-1:0] wq[$];

  mem_burst_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .StartWrite(StartWrite), .WriteAddress(WriteAddress),
    .WriteBurst(WriteBurst), .WriteStrobe(WriteStrobe), .WriteData(WriteData),
    .WriteReady(WriteReady), .WriteResp(WriteResp), .EndWrite(EndWrite), .StartRead(StartRead),
    .ReadAddress(ReadAddress), .ReadBurst(ReadBurst), .ReadData(ReadData), .ReadReady(ReadReady),
    .EndRead(EndRead), .busy(busy), .cmd_err(cmd_err), .protocol_err(protocol_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    #4;
    if (StartRead) n_srd++;
    if (StartWrite) n_swr++;
    if (rdata_valid && rdata_ready) begin
      chk("rq_nonempty", rq.size() != 0, 1);
      if (rq.size() != 0) chk("rdata", {rdata, rdata_last}, rq.pop_front());
    end
    if (WriteReady) begin
      chk("wq_nonempty", wq.size() != 0, 1);
      if (wq.size() != 0) chk("wdata_out", WriteData, wq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [AW-1:0] a, input logic [7:0] l);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_srd(input int budget);
    int s = n_srd;
    for (int i = 0; i < budget && n_srd == s; i++) tick();
    chk("start_rd_seen", n_srd, s + 1);
  endtask

  task automatic wait_swr(input int budget);
    int s = n_swr;
    for (int i = 0; i < budget && n_swr == s; i++) tick();
    chk("start_wr_seen", n_swr, s + 1);
  endtask

  task automatic read_beats(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      ReadReady = 1; ReadData = DW'(base + i); EndRead = (i == n - 1);
      rq.push_back({ReadData, EndRead});
      tick();
    end
    ReadReady = 0; EndRead = 0;
  endtask

  task automatic write_fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      chk("wdata_ready", wdata_ready, 1);
      wdata_valid = 1; wdata = DW'(base + i);
      wq.push_back(wdata);
      tick();
    end
    wdata_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", {StartRead, StartWrite, WriteReady}, 0);
    chk("rst_strobe", WriteStrobe, {(DW/8){1'b1}});
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_errs", {cmd_err, protocol_err, timeout_err}, 0);
    chk("rst_addr", ReadAddress, 0);
    reset = 0;
    tick();

    rdata_ready = 1;
    cmd(0, 'h100, 3);
    chk("rd_busy", busy, 1);
    wait_srd(10);
    chk("rd_addr", ReadAddress, 'h100);
    chk("rd_burst", ReadBurst, 3);
    read_beats(4, 'hA0);
    chk("rd_done_busy", busy, 0);
    chk("rd_idle_addr", ReadAddress, 0);
    repeat (3) tick();
    chk("rd_drained", rq.size(), 0);
    chk("rd_pulses", n_srd, 1);

    cmd(1, 'h2000, 7);
    write_fill(8, 'hB000);
    chk("wdata_ready_off", wdata_ready, 0);
    wait_swr(5);
    chk("wr_addr", WriteAddress, 'h2000);
    chk("wr_burst", WriteBurst, 7);
    chk("wr_strobe", WriteStrobe, {(DW/8){1'b1}});
    for (int i = 0; i < 8; i++) begin
      chk("wready_run", WriteReady, 1);
      tick();
    end
    chk("wready_end", WriteReady, 0);
    chk("wr_drained", wq.size(), 0);
    chk("wr_wait_busy", busy, 1);
    EndWrite = 2'b01;
    tick();
    EndWrite = 2'b00;
    chk("wr_done_busy", busy, 0);
    chk("wr_idle_addr", WriteAddress, 0);
    chk("no_proto", protocol_err, 0);

    rdata_ready = 0;
    for (int r = 0; r < 2; r++) begin
      cmd(0, AW'('h1000 + r * 'h200), 15);
      wait_srd(10);
      read_beats(16, 'h1000 * (r + 1));
    end
    cmd(0, 'h5000, 15);
    repeat (10) tick();
    chk("bp_withheld", n_srd, 3);
    rdata_ready = 1;
    repeat (15) tick();
    rdata_ready = 0;
    repeat (4) tick();
    chk("bp_withheld15", n_srd, 3);
    rdata_ready = 1;
    tick();
    rdata_ready = 0;
    wait_srd(6);
    read_beats(16, 'h9000);
    rdata_ready = 1;
    repeat (40) tick();
    chk("bp_drained", rq.size(), 0);

    cmd(0, 'h300, 40);
    chk("ill_err", cmd_err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_ready", cmd_ready, 1);
    repeat (4) tick();
    chk("ill_no_start", {n_srd, n_swr}, {32'd4, 32'd1});

    cmd(1, 'h3000, 7);
    write_fill(8, 'hD000);
    wait_swr(5);
    repeat (3) tick();
    chk("pre_rst_wready", WriteReady, 1);
    reset = 1;
    #1;
    chk("arst_wready", WriteReady, 0);
    chk("arst_start", {StartRead, StartWrite}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_errs", {cmd_err, protocol_err, timeout_err}, 0);
    chk("arst_wdata", WriteData, 0);
    chk("arst_waddr", WriteAddress, 0);
    wq.delete();
    tick();
    reset = 0;
    tick();
    cmd(0, 'h400, 1);
    wait_srd(10);
    chk("post_rst_burst", ReadBurst, 1);
    read_beats(2, 'hC0);
    repeat (3) tick();
    chk("post_rst_drained", rq.size(), 0);
    chk("post_rst_busy", busy, 0);

`ifdef MEM_INIT_TIMEOUT_EN
    cmd(0, 'h500, 0);
    wait_srd(10);
    for (int i = 0; i < 40 && !timeout_err; i++) tick();
    chk("timeout_err", timeout_err, 1);
    chk("timeout_idle", busy, 0);
`else
    chk("timeout_tied", timeout_err, 0);
`endif

    ReadReady = 1;
    tick();
    ReadReady = 0;
    chk("proto_err", protocol_err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
